hiscore_ram_arbiter: RTL and testbench

//  Shares the game CPU work-RAM port between the running CPU and the hiscore save/restore engine.

---
 rtl/hiscore_ram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_arbiter.sv
// Hiscore RAM arbiter: borrows the CPU work-RAM port for the hiscore engine
// by pausing the CPU, settling, then muxing single-beat accesses onto RAM.
module hiscore_ram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RAM_LAT    = 1,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          hs_req,
  input  logic          hs_strobe,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic          hs_grant,
  output logic          hs_ack,
  output logic          hs_rvalid,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_abort,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_paused,
  output logic          pause_req,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSING,
    S_SETTLE,
    S_GRANT,
    S_RELEASE,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          pause_q, pause_d;
  logic          grant_q, grant_d;
  logic          ack_q, ack_d;
  logic          rvalid_q, rvalid_d;
  logic          abort_q, abort_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          acc_q, acc_d;
  logic          acc_we_q, acc_we_d;
  logic [AW-1:0] acc_addr_q, acc_addr_d;
  logic [DW-1:0] acc_wdata_q, acc_wdata_d;
  logic [RAM_LAT-1:0] pipe_q, pipe_d;

  logic rd_issue;
  logic rd_busy;

  // A read occupies the port from its address beat until its data returns.
  assign rd_issue = acc_q & ~acc_we_q;
  assign rd_busy  = rd_issue | (|pipe_q);

  // RAM port mux: CPU passes straight through unless hiscore owns the port.
  assign ram_addr  = sel_q ? acc_addr_q  : cpu_addr;
  assign ram_wdata = sel_q ? acc_wdata_q : cpu_wdata;
  assign ram_we    = sel_q ? (acc_q & acc_we_q) : cpu_we;

  assign hs_grant  = grant_q;
  assign hs_ack    = ack_q;
  assign hs_rvalid = rvalid_q;
  assign hs_rdata  = rdata_q;
  assign hs_abort  = abort_q;
  assign pause_req = pause_q;

  // State register; reset discards any access or read in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      pause_q     <= 1'b0;
      grant_q     <= 1'b0;
      ack_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      abort_q     <= 1'b0;
      rdata_q     <= '0;
      timer_q     <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      acc_q       <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pause_q     <= pause_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      abort_q     <= abort_d;
      rdata_q     <= rdata_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      acc_q       <= acc_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      pipe_q      <= pipe_d;
    end
  end

  // Next-state: session sequencing, access capture and read return.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pause_d     = pause_q;
    grant_d     = grant_q;
    ack_d       = 1'b0;
    rvalid_d    = 1'b0;
    abort_d     = 1'b0;
    rdata_d     = rdata_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q | ~hs_req;
    acc_d       = 1'b0;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    pipe_d      = pipe_q << 1;
    pipe_d[0]   = rd_issue;

    if (pipe_q[RAM_LAT-1]) begin
      rvalid_d = 1'b1;
      rdata_d  = ram_rdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (hs_req && armed_q) begin
          state_d = S_PAUSING;
          pause_d = 1'b1;
          timer_d = '0;
          armed_d = 1'b0;
        end
      end
      S_PAUSING: begin
        if (!hs_req) begin
          pause_d = 1'b0;
          state_d = S_IDLE;
        end else if (cpu_paused) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (timer_q == TW'(TIMEOUT)) begin
          abort_d = 1'b1;
          pause_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (!hs_req) begin
          pause_d = 1'b0;
          state_d = S_IDLE;
        end else if (!cpu_paused) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = S_GRANT;
          sel_d   = 1'b1;
          grant_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GRANT: begin
        if (!hs_req) begin
          state_d = S_RELEASE;
          grant_d = 1'b0;
        end else if (hs_strobe && !rd_busy) begin
          acc_d       = 1'b1;
          ack_d       = 1'b1;
          acc_we_d    = hs_we;
          acc_addr_d  = hs_addr;
          acc_wdata_d = hs_wdata;
        end
      end
      S_RELEASE: begin
        if (!rd_busy) begin
          sel_d   = 1'b0;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        pause_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Testbench for hiscore_ram_arbiter: randomized sessions checked against
// a RAM scoreboard and timing rules computed from the parameters.
module tb_hiscore_ram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int SC  = 4;
  localparam int TO  = 15;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          hs_req, hs_strobe, hs_we;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wdata;
  logic          hs_grant, hs_ack, hs_rvalid, hs_abort;
  logic [DW-1:0] hs_rdata;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we, cpu_paused;
  logic          pause_req;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  bit cpu_rnd = 1'b0;

  always #5 clk_sys = ~clk_sys;

  hiscore_ram_arbiter #(
    .AW(AW), .DW(DW), .RAM_LAT(LAT),
    .SETTLE_CYC(SC), .TIMEOUT(TO)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .hs_req(hs_req), .hs_strobe(hs_strobe), .hs_we(hs_we),
    .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_grant(hs_grant), .hs_ack(hs_ack), .hs_rvalid(hs_rvalid),
    .hs_rdata(hs_rdata), .hs_abort(hs_abort),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_paused(cpu_paused), .pause_req(pause_req),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  // RAM model with LAT cycles from address to data
  logic [DW-1:0] mem [int];
  logic [DW-1:0] rd_q [LAT];
  logic [DW-1:0] sb [int];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [DW-1:0] ram_peek(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] exp_of(input logic [AW-1:0] a);
    return sb.exists(int'(a)) ? sb[int'(a)] : init_val(a);
  endfunction

  always @(posedge clk_sys) begin
    rd_q[0] <= ram_peek(ram_addr);
    for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
    if (ram_we) mem[int'(ram_addr)] = ram_wdata;
  end
  assign ram_rdata = rd_q[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (cpu_rnd) begin
      cpu_addr  = 16'($urandom_range(0, 255));
      cpu_wdata = 8'($urandom);
      cpu_we    = 1'($urandom);
    end
    #1;
  endtask

  task automatic grant_up(input int pd, input bit glitch);
    int n;
    cpu_paused = 1'b0;
    hs_req = 1'b1;
    tick();
    chk("pause_rise", pause_req, 1);
    chk("grant_lo", hs_grant, 0);
    chk("mux_cpu", ram_addr, cpu_addr);
    repeat (pd) tick();
    cpu_paused = 1'b1;
    n = 0;
    if (glitch) begin
      tick(); tick();
      cpu_paused = 1'b0;
      tick();
      cpu_paused = 1'b1;
      n = 3;
    end
    while (!hs_grant && n < 50) begin
      tick();
      n++;
    end
    chk("grant_lat", n, glitch ? 3 + SC : 1 + SC);
  endtask

  task automatic access(input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit stall);
    int n;
    logic [DW-1:0] e;
    hs_strobe = 1'b1;
    hs_we = we;
    hs_addr = a;
    hs_wdata = d;
    tick();
    hs_strobe = 1'b0;
    chk("ack", hs_ack, 1);
    if (we) begin
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, a);
      chk("wr_data", ram_wdata, d);
      sb[int'(a)] = d;
      tick();
      chk("wr_single", ram_we, 0);
    end else begin
      e = exp_of(a);
      n = 0;
      if (stall) begin
        hs_strobe = 1'b1;
        hs_we = 1'b1;
        hs_addr = a ^ 16'h0001;
      end
      do begin
        tick();
        n++;
        if (stall && n == 1) begin
          chk("stall_noack", hs_ack, 0);
          hs_strobe = 1'b0;
        end
        chk("rd_no_we", ram_we, 0);
      end while (!hs_rvalid && n < 20);
      chk("rd_lat", n, LAT + 1);
      chk("rd_data", hs_rdata, e);
    end
  endtask

  // mode 0: plain, 1: read in flight, 2: strobe with hs_req fall
  task automatic release_hs(input int mode, input logic [AW-1:0] a);
    int n, t_rv, t_sel, t_pz;
    logic [DW-1:0] e;
    e = exp_of(a);
    if (mode == 1) begin
      hs_strobe = 1'b1;
      hs_we = 1'b0;
      hs_addr = a;
      tick();
      hs_strobe = 1'b0;
      chk("rel_ack", hs_ack, 1);
    end
    if (mode == 2) begin
      hs_strobe = 1'b1;
      hs_we = 1'b1;
      hs_addr = a;
      hs_wdata = ~e;
    end
    hs_req = 1'b0;
    tick();
    hs_strobe = 1'b0;
    chk("rel_grant_lo", hs_grant, 0);
    if (mode == 2) begin
      chk("sim_noack", hs_ack, 0);
      chk("sim_no_we", ram_we, 0);
    end
    n = 0; t_rv = -1; t_sel = -1; t_pz = -1;
    while (t_pz < 0 && n < 30) begin
      tick();
      n++;
      if (hs_rvalid) begin
        t_rv = n;
        chk("rel_rdata", hs_rdata, e);
      end
      if (t_sel < 0 && ram_addr == cpu_addr && ram_we == cpu_we &&
          ram_wdata == cpu_wdata) t_sel = n;
      if (!pause_req) t_pz = n;
    end
    chk("pause_after_ram", t_pz, t_sel + 1);
    if (mode == 1) begin
      chk("rel_rv_time", t_rv, LAT);
      chk("sel_after_rv", t_sel, t_rv + 1);
    end else begin
      chk("rel_sel_time", t_sel, 1);
    end
    cpu_paused = 1'b0;
  endtask

  task automatic timeout_test();
    int n;
    cpu_paused = 1'b0;
    hs_req = 1'b1;
    tick();
    chk("to_pause_rise", pause_req, 1);
    n = 0;
    while (!hs_abort && n < 100) begin
      tick();
      n++;
    end
    chk("to_lat", n, TO + 1);
    chk("to_pause_lo", pause_req, 0);
    tick();
    chk("abort_pulse", hs_abort, 0);
    repeat (5) tick();
    chk("no_rearm", pause_req, 0);
    hs_req = 1'b0;
    tick();
    hs_req = 1'b1;
    tick();
    chk("rearm", pause_req, 1);
    hs_req = 1'b0;
    tick();
    chk("abandon", pause_req, 0);
    chk("abandon_abort", hs_abort, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] e;
    reset = 1'b1;
    hs_req = 1'b0; hs_strobe = 1'b0; hs_we = 1'b0;
    hs_addr = '0; hs_wdata = '0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    cpu_paused = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pause", pause_req, 0);
    chk("rst_grant", hs_grant, 0);
    chk("rst_ack", hs_ack, 0);
    chk("rst_rvalid", hs_rvalid, 0);
    chk("rst_abort", hs_abort, 0);
    chk("rst_rdata", hs_rdata, 0);

    cpu_addr = 16'h1234; cpu_we = 1'b1; cpu_wdata = 8'hA5;
    #1;
    chk("pt_addr", ram_addr, 16'h1234);
    chk("pt_we", ram_we, 1);
    chk("pt_wdata", ram_wdata, 8'hA5);
    chk("pt_pause", pause_req, 0);
    cpu_we = 1'b0;
    cpu_rnd = 1'b1;

    grant_up(3, 1'b0);
    access(1'b1, 16'h8A00, 8'h5C, 1'b0);
    access(1'b0, 16'h8A00, 8'h00, 1'b0);
    release_hs(1, 16'h8A00);

    timeout_test();

    for (int s = 0; s < 8; s++) begin
      grant_up($urandom_range(0, 12), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(3, 8)); k++)
        access(1'($urandom), 16'h8A00 | 16'($urandom_range(0, 15)),
               8'($urandom), $urandom_range(0, 3) == 0);
      release_hs($urandom_range(0, 2),
                 16'h8A00 | 16'($urandom_range(0, 15)));
    end

    grant_up(2, 1'b0);
    access(1'b0, 16'h8A03, 8'h00, 1'b0);
    e = exp_of(16'h8A05);
    hs_strobe = 1'b1; hs_we = 1'b1;
    hs_addr = 16'h8A05; hs_wdata = ~e;
    reset = 1'b1;
    hs_req = 1'b0;
    tick();
    hs_strobe = 1'b0;
    chk("mr_pause", pause_req, 0);
    chk("mr_grant", hs_grant, 0);
    chk("mr_ack", hs_ack, 0);
    chk("mr_rvalid", hs_rvalid, 0);
    chk("mr_abort", hs_abort, 0);
    chk("mr_rdata", hs_rdata, 0);
    chk("mr_addr", ram_addr, cpu_addr);
    chk("mr_we", ram_we, cpu_we);
    reset = 1'b0;
    tick();
    chk("mr_no_hs_wr", ram_peek(16'h8A05), e);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
